// File: rtl/reg_decode_pkg.sv
// Shared constants and types for the DLX decode stage: opcodes, R-type
// function codes, ALU operation encodings and the decoded control bundle.
package reg_decode_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQZ  = 6'd4;
  localparam logic [5:0] OP_BNEZ  = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDUI = 6'd9;
  localparam logic [5:0] OP_SUBI  = 6'd10;
  localparam logic [5:0] OP_SUBUI = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_LHI   = 6'd15;
  localparam logic [5:0] OP_JR    = 6'd18;
  localparam logic [5:0] OP_JALR  = 6'd19;
  localparam logic [5:0] OP_SLLI  = 6'd20;
  localparam logic [5:0] OP_SRLI  = 6'd22;
  localparam logic [5:0] OP_SRAI  = 6'd23;
  localparam logic [5:0] OP_SEQI  = 6'd24;
  localparam logic [5:0] OP_SNEI  = 6'd25;
  localparam logic [5:0] OP_SLTI  = 6'd26;
  localparam logic [5:0] OP_SGTI  = 6'd27;
  localparam logic [5:0] OP_SLEI  = 6'd28;
  localparam logic [5:0] OP_SGEI  = 6'd29;
  localparam logic [5:0] OP_LB    = 6'd32;
  localparam logic [5:0] OP_LH    = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_LBU   = 6'd36;
  localparam logic [5:0] OP_LHU   = 6'd37;
  localparam logic [5:0] OP_LF    = 6'd38;
  localparam logic [5:0] OP_SB    = 6'd40;
  localparam logic [5:0] OP_SH    = 6'd41;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_SF    = 6'd46;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SGT  = 6'h2B;
  localparam logic [5:0] FN_SLE  = 6'h2C;
  localparam logic [5:0] FN_SGE  = 6'h2D;

  // Link register used by JAL/JALR
  localparam logic [4:0] REG_LINK = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,  ALU_SLL = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_SEQ = 4'd8,  ALU_SNE = 4'd9,  ALU_SLT = 4'd10, ALU_SGT = 4'd11,
    ALU_SLE = 4'd12, ALU_SGE = 4'd13, ALU_LHI = 4'd14, ALU_PASSA = 4'd15
  } alu_op_t;

  // Everything the decoder derives from one instruction word
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       mem2reg;
    logic       regwrite;
    logic       memwrite;
    logic       loadext;
    logic       jal;
    alu_op_t    aluctrl;
    logic [1:0] fpoint;
    logic [1:0] dsize;
    logic       beqz;
    logic       bnez;
    logic       jump;
    logic       jar;
    logic       zext;
    logic       imm26;
  } ctrl_t;

endpackage

// File: rtl/reg_decode_rf.sv
// Dual register file: 32x32 integer (r0 hard-wired to zero) and 32x32 FP.
// Two combinational read ports with write-through, one synchronous write port.
module reg_decode_rf
  import reg_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        rb_fp,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        wr_en,
  input  logic        wr_fp,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b
);

  logic [31:0] int_r [32];
  logic [31:0] fp_r  [32];

  // Storage update: async clear of both files, otherwise one write per cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        int_r[i] <= 32'd0;
        fp_r[i]  <= 32'd0;
      end
    end else if (wr_en) begin
      if (wr_fp) begin
        fp_r[wr_addr] <= wr_data;
      end else if (wr_addr != 5'd0) begin
        int_r[wr_addr] <= wr_data;
      end
    end
  end

  // Port A always reads the integer file; a same-cycle write is bypassed
  always_comb begin
    rd_a = 32'd0;
    if (ra == 5'd0) begin
      rd_a = 32'd0;
    end else if (wr_en && !wr_fp && (wr_addr == ra)) begin
      rd_a = wr_data;
    end else begin
      rd_a = int_r[ra];
    end
  end

  // Port B reads the FP file when requested (FP store data), else integer
  always_comb begin
    rd_b = 32'd0;
    if (rb_fp) begin
      if (wr_en && wr_fp && (wr_addr == rb)) begin
        rd_b = wr_data;
      end else begin
        rd_b = fp_r[rb];
      end
    end else if (rb == 5'd0) begin
      rd_b = 32'd0;
    end else if (wr_en && !wr_fp && (wr_addr == rb)) begin
      rd_b = wr_data;
    end else begin
      rd_b = int_r[rb];
    end
  end

endmodule

// File: rtl/reg_decode.sv
// DLX instruction decode stage: control decode, register read with operand
// forwarding, zero-latency branch/jump redirect and the ID/EX pipeline register.
module reg_decode
  import reg_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  input  logic [4:0]  rw_wb,
  input  logic [31:0] busW,
  input  logic        wrenable,
  input  logic [1:0]  fpoint_wb,
  input  logic [31:0] aluout,
  input  logic [31:0] source,
  input  logic [1:0]  fwdA,
  input  logic [1:0]  fwdB,
  output logic        branch,
  output logic        jump,
  output logic        jar,
  output logic [31:0] branchtarget,
  output logic [31:0] instr_out,
  output logic [31:0] imm32,
  output logic [31:0] busA,
  output logic [31:0] busB,
  output logic [31:0] link,
  output logic        regdst,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        memwrite,
  output logic        loadext,
  output logic        jal,
  output logic [3:0]  aluctrl,
  output logic [1:0]  fpoint,
  output logic [4:0]  rw,
  output logic [1:0]  dsize
);

  logic [5:0]  op_s;
  logic [5:0]  func_s;
  ctrl_t       ctrl_s;
  logic [31:0] rf_a_s;
  logic [31:0] rf_b_s;
  logic [31:0] opa_s;
  logic [31:0] opb_s;
  logic [31:0] imm32_s;
  logic [4:0]  rw_s;
  logic        unused_s;

  assign op_s     = instr_in[31:26];
  assign func_s   = instr_in[5:0];
  // Only the file-select bit of the write-back selector matters here
  assign unused_s = fpoint_wb[1];

  reg_decode_rf u_rf (
    .clock   (clock),
    .reset   (reset),
    .ra      (instr_in[25:21]),
    .rb      (instr_in[20:16]),
    .rb_fp   (op_s == OP_SF),
    .wr_addr (rw_wb),
    .wr_data (busW),
    .wr_en   (wrenable),
    .wr_fp   (fpoint_wb[0]),
    .rd_a    (rf_a_s),
    .rd_b    (rf_b_s)
  );

  // Instruction decode into a control bundle; unknown encodings become a NOP
  always_comb begin
    ctrl_s = '0;
    case (op_s)
      OP_RTYPE: begin
        ctrl_s.regdst   = 1'b1;
        ctrl_s.regwrite = 1'b1;
        case (func_s)
          FN_ADD, FN_ADDU: ctrl_s.aluctrl = ALU_ADD;
          FN_SUB, FN_SUBU: ctrl_s.aluctrl = ALU_SUB;
          FN_AND:          ctrl_s.aluctrl = ALU_AND;
          FN_OR:           ctrl_s.aluctrl = ALU_OR;
          FN_XOR:          ctrl_s.aluctrl = ALU_XOR;
          FN_SLL:          ctrl_s.aluctrl = ALU_SLL;
          FN_SRL:          ctrl_s.aluctrl = ALU_SRL;
          FN_SRA:          ctrl_s.aluctrl = ALU_SRA;
          FN_SEQ, FN_SNE, FN_SLT, FN_SGT, FN_SLE, FN_SGE:
                           ctrl_s.aluctrl = alu_op_t'({1'b1, func_s[2:0]});
          default: begin
            ctrl_s.regdst   = 1'b0;
            ctrl_s.regwrite = 1'b0;
          end
        endcase
      end
      OP_J:    begin ctrl_s.alusrc = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.imm26 = 1'b1; end
      OP_JAL:  begin
        ctrl_s.alusrc = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.imm26 = 1'b1;
        ctrl_s.jal = 1'b1; ctrl_s.regwrite = 1'b1;
      end
      OP_BEQZ: begin ctrl_s.alusrc = 1'b1; ctrl_s.beqz = 1'b1; end
      OP_BNEZ: begin ctrl_s.alusrc = 1'b1; ctrl_s.bnez = 1'b1; end
      OP_ADDI: begin ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_ADD; end
      OP_ADDUI: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_ADD; ctrl_s.zext = 1'b1;
      end
      OP_SUBI: begin ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_SUB; end
      OP_SUBUI: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_SUB; ctrl_s.zext = 1'b1;
      end
      OP_ANDI: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_AND; ctrl_s.zext = 1'b1;
      end
      OP_ORI: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_OR; ctrl_s.zext = 1'b1;
      end
      OP_XORI: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_XOR; ctrl_s.zext = 1'b1;
      end
      OP_LHI:  begin ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_LHI; end
      OP_JR:   begin ctrl_s.alusrc = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.jar = 1'b1; end
      OP_JALR: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.jar = 1'b1;
        ctrl_s.jal = 1'b1; ctrl_s.regwrite = 1'b1;
      end
      OP_SLLI: begin ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_SLL; end
      OP_SRLI: begin ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_SRL; end
      OP_SRAI: begin ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.aluctrl = ALU_SRA; end
      OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: begin
        // Set-compare opcodes 24..29 map onto ALU codes 8..13 through the low bits
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1;
        ctrl_s.aluctrl = alu_op_t'({1'b1, op_s[2:0]});
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LF: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1; ctrl_s.mem2reg = 1'b1;
        ctrl_s.loadext = (op_s == OP_LB) || (op_s == OP_LH);
        ctrl_s.fpoint  = (op_s == OP_LF) ? 2'b01 : 2'b00;
        if ((op_s == OP_LB) || (op_s == OP_LBU)) begin
          ctrl_s.dsize = 2'b00;
        end else if ((op_s == OP_LH) || (op_s == OP_LHU)) begin
          ctrl_s.dsize = 2'b01;
        end else begin
          ctrl_s.dsize = 2'b10;
        end
      end
      OP_SB:   begin ctrl_s.alusrc = 1'b1; ctrl_s.memwrite = 1'b1; ctrl_s.dsize = 2'b00; end
      OP_SH:   begin ctrl_s.alusrc = 1'b1; ctrl_s.memwrite = 1'b1; ctrl_s.dsize = 2'b01; end
      OP_SW:   begin ctrl_s.alusrc = 1'b1; ctrl_s.memwrite = 1'b1; ctrl_s.dsize = 2'b10; end
      OP_SF: begin
        ctrl_s.alusrc = 1'b1; ctrl_s.memwrite = 1'b1; ctrl_s.dsize = 2'b10; ctrl_s.fpoint = 2'b10;
      end
      default: ctrl_s = '0;
    endcase
  end

  // Immediate extension, forwarding muxes and destination register select
  always_comb begin
    imm32_s = {{16{instr_in[15]}}, instr_in[15:0]};
    if (ctrl_s.imm26) begin
      imm32_s = {{6{instr_in[25]}}, instr_in[25:0]};
    end else if (ctrl_s.zext) begin
      imm32_s = {16'h0000, instr_in[15:0]};
    end else begin
      imm32_s = {{16{instr_in[15]}}, instr_in[15:0]};
    end
    case (fwdA)
      2'b01:   opa_s = aluout;
      2'b10:   opa_s = source;
      default: opa_s = rf_a_s;
    endcase
    case (fwdB)
      2'b01:   opb_s = aluout;
      2'b10:   opb_s = source;
      default: opb_s = rf_b_s;
    endcase
    if (ctrl_s.jal) begin
      rw_s = REG_LINK;
    end else if (ctrl_s.regdst) begin
      rw_s = instr_in[15:11];
    end else begin
      rw_s = instr_in[20:16];
    end
  end

  // Zero-latency fetch redirect, suppressed while a bubble is being inserted
  always_comb begin
    branch       = 1'b0;
    jump         = 1'b0;
    jar          = 1'b0;
    branchtarget = 32'd0;
    if (stall) begin
      branch       = 1'b0;
      jump         = 1'b0;
      jar          = 1'b0;
      branchtarget = 32'd0;
    end else begin
      branch       = (ctrl_s.beqz && (opa_s == 32'd0)) || (ctrl_s.bnez && (opa_s != 32'd0));
      jump         = ctrl_s.jump;
      jar          = ctrl_s.jar;
      branchtarget = ctrl_s.jar ? opa_s : (pc4_in + imm32_s);
    end
  end

  // ID/EX pipeline register: async clear, bubble on stall, else capture decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset || stall) begin
      instr_out <= 32'd0; imm32 <= 32'd0; busA <= 32'd0; busB <= 32'd0; link <= 32'd0;
      regdst <= 1'b0; alusrc <= 1'b0; mem2reg <= 1'b0; regwrite <= 1'b0;
      memwrite <= 1'b0; loadext <= 1'b0; jal <= 1'b0;
      aluctrl <= 4'd0; fpoint <= 2'b00; rw <= 5'd0; dsize <= 2'b00;
    end else begin
      instr_out <= instr_in;
      imm32     <= imm32_s;
      busA      <= opa_s;
      busB      <= opb_s;
      link      <= pc4_in + 32'd4;
      regdst    <= ctrl_s.regdst;
      alusrc    <= ctrl_s.alusrc;
      mem2reg   <= ctrl_s.mem2reg;
      regwrite  <= ctrl_s.regwrite;
      memwrite  <= ctrl_s.memwrite;
      loadext   <= ctrl_s.loadext;
      jal       <= ctrl_s.jal;
      aluctrl   <= ctrl_s.aluctrl;
      fpoint    <= ctrl_s.fpoint;
      rw        <= rw_s;
      dsize     <= ctrl_s.dsize;
    end
  end

endmodule

// File: tb/tb_reg_decode.sv
// Directed self-checking bench for reg_decode.
module tb_reg_decode;

  logic        clock, reset, stall, wrenable;
  logic [31:0] instr_in, pc4_in, busW, aluout, source;
  logic [4:0]  rw_wb;
  logic [1:0]  fpoint_wb, fwdA, fwdB;
  logic        branch, jump, jar;
  logic [31:0] branchtarget, instr_out, imm32, busA, busB, link;
  logic        regdst, alusrc, mem2reg, regwrite, memwrite, loadext, jal;
  logic [3:0]  aluctrl;
  logic [1:0]  fpoint, dsize;
  logic [4:0]  rw;

  int passed = 0;
  int total  = 0;

  reg_decode dut (
    .clock(clock), .reset(reset), .stall(stall), .instr_in(instr_in), .pc4_in(pc4_in),
    .rw_wb(rw_wb), .busW(busW), .wrenable(wrenable), .fpoint_wb(fpoint_wb),
    .aluout(aluout), .source(source), .fwdA(fwdA), .fwdB(fwdB),
    .branch(branch), .jump(jump), .jar(jar), .branchtarget(branchtarget),
    .instr_out(instr_out), .imm32(imm32), .busA(busA), .busB(busB), .link(link),
    .regdst(regdst), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
    .memwrite(memwrite), .loadext(loadext), .jal(jal), .aluctrl(aluctrl),
    .fpoint(fpoint), .rw(rw), .dsize(dsize)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d, input logic [1:0] fp);
    rw_wb = r; busW = d; fpoint_wb = fp; wrenable = 1'b1;
    tick;
    wrenable = 1'b0; fpoint_wb = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0; wrenable = 1'b0; rw_wb = 5'd0; busW = 32'd0;
    fpoint_wb = 2'b00; aluout = 32'd0; source = 32'd0; fwdA = 2'b00; fwdB = 2'b00;
    pc4_in = 32'h0000_0100; instr_in = 32'h00A0_1820;
    #1 reset = 1'b0;
    #1;
    total++; if (regwrite !== 1'b0) $display("FAIL rst_regwrite got %0h exp 0", regwrite); else passed++;
    tick;
    total++; if (instr_out !== 32'd0) $display("FAIL rst_instr_out got %h exp 00000000", instr_out); else passed++;
    total++; if (link !== 32'd0) $display("FAIL rst_link got %h exp 00000000", link); else passed++;
    total++; if (rw !== 5'd0) $display("FAIL rst_rw got %0d exp 0", rw); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_add;
    instr_in = 32'd0;
    wb_write(5'd5, 32'h1234_5678, 2'b00);
    instr_in = 32'h00A0_1820; // ADD r3,r5,r0
    tick;
    total++; if (busA !== 32'h1234_5678) $display("FAIL add_busA got %h exp 12345678", busA); else passed++;
    total++; if (rw !== 5'd3) $display("FAIL add_rw got %0d exp 3", rw); else passed++;
    total++; if (regwrite !== 1'b1) $display("FAIL add_regwrite got %0h exp 1", regwrite); else passed++;
    total++; if (aluctrl !== 4'd0) $display("FAIL add_aluctrl got %0d exp 0", aluctrl); else passed++;
    total++; if (regdst !== 1'b1 || alusrc !== 1'b0) $display("FAIL add_regdst_alusrc got %0h%0h exp 10", regdst, alusrc); else passed++;
    total++; if (instr_out !== 32'h00A0_1820) $display("FAIL add_instr_out got %h exp 00a01820", instr_out); else passed++;
    // Same-cycle write of r5 must be seen by the read
    rw_wb = 5'd5; busW = 32'hCAFE_BABE; wrenable = 1'b1;
    tick;
    wrenable = 1'b0;
    total++; if (busA !== 32'hCAFE_BABE) $display("FAIL wt_busA got %h exp cafebabe", busA); else passed++;
    instr_in = 32'h00A5_2022; // SUB r4,r5,r5
    tick;
    total++; if (aluctrl !== 4'd1) $display("FAIL sub_aluctrl got %0d exp 1", aluctrl); else passed++;
    total++; if (busB !== 32'hCAFE_BABE) $display("FAIL sub_busB got %h exp cafebabe", busB); else passed++;
    total++; if (rw !== 5'd4) $display("FAIL sub_rw got %0d exp 4", rw); else passed++;
    instr_in = 32'h00A5_202A; // SLT
    fwdA = 2'b01; aluout = 32'h0000_0011; fwdB = 2'b10; source = 32'h0000_55AA;
    tick;
    total++; if (aluctrl !== 4'd10) $display("FAIL slt_aluctrl got %0d exp 10", aluctrl); else passed++;
    total++; if (busA !== 32'h0000_0011) $display("FAIL fwdA01_busA got %h exp 00000011", busA); else passed++;
    total++; if (busB !== 32'h0000_55AA) $display("FAIL fwdB10_busB got %h exp 000055aa", busB); else passed++;
    fwdA = 2'b11; fwdB = 2'b00;
    tick;
    total++; if (busA !== 32'hCAFE_BABE) $display("FAIL fwdA11_busA got %h exp cafebabe", busA); else passed++;
    fwdA = 2'b00;
  endtask

  task automatic test_branch;
    pc4_in = 32'h0000_0200; fwdA = 2'b01;
    instr_in = 32'h1020_0008; aluout = 32'd0; // BEQZ r1,+8
    #1;
    total++; if (branch !== 1'b1) $display("FAIL beqz_taken got %0h exp 1", branch); else passed++;
    total++; if (branchtarget !== 32'h0000_0208) $display("FAIL beqz_target got %h exp 00000208", branchtarget); else passed++;
    total++; if (jump !== 1'b0) $display("FAIL beqz_jump got %0h exp 0", jump); else passed++;
    aluout = 32'd1;
    #1;
    total++; if (branch !== 1'b0) $display("FAIL beqz_nottaken got %0h exp 0", branch); else passed++;
    instr_in = 32'h1420_0008; // BNEZ r1,+8
    #1;
    total++; if (branch !== 1'b1) $display("FAIL bnez_taken got %0h exp 1", branch); else passed++;
    instr_in = 32'h1020_FFF8; fwdA = 2'b10; source = 32'd0; // BEQZ r1,-8
    #1;
    total++; if (branch !== 1'b1 || branchtarget !== 32'h0000_01F8) $display("FAIL beqz_neg got %0h %h exp 1 000001f8", branch, branchtarget); else passed++;
    tick;
    total++; if (regwrite !== 1'b0 || memwrite !== 1'b0) $display("FAIL beqz_nowrite got %0h%0h exp 00", regwrite, memwrite); else passed++;
    fwdA = 2'b00;
  endtask

  task automatic test_jump;
    wb_write(5'd7, 32'h0000_0400, 2'b00);
    pc4_in = 32'h0000_0100; instr_in = 32'h4CE0_0000; // JALR r7
    #1;
    total++; if (jump !== 1'b1 || jar !== 1'b1) $display("FAIL jalr_jump_jar got %0h%0h exp 11", jump, jar); else passed++;
    total++; if (branchtarget !== 32'h0000_0400) $display("FAIL jalr_target got %h exp 00000400", branchtarget); else passed++;
    tick;
    total++; if (rw !== 5'd31) $display("FAIL jalr_rw got %0d exp 31", rw); else passed++;
    total++; if (jal !== 1'b1 || regwrite !== 1'b1) $display("FAIL jalr_jal_rw got %0h%0h exp 11", jal, regwrite); else passed++;
    total++; if (link !== 32'h0000_0104) $display("FAIL jalr_link got %h exp 00000104", link); else passed++;
    instr_in = 32'h0BFF_FFFC; // J -4
    #1;
    total++; if (jump !== 1'b1 || jar !== 1'b0 || branchtarget !== 32'h0000_00FC) $display("FAIL j_redirect got %0h%0h %h exp 10 000000fc", jump, jar, branchtarget); else passed++;
    tick;
    total++; if (imm32 !== 32'hFFFF_FFFC || regwrite !== 1'b0) $display("FAIL j_imm got %h %0h exp fffffffc 0", imm32, regwrite); else passed++;
  endtask

  task automatic test_imm;
    instr_in = 32'h8082_FFFC; // LB r2,-4(r4)
    tick;
    total++; if (mem2reg !== 1'b1 || loadext !== 1'b1 || dsize !== 2'b00) $display("FAIL lb_ctrl got %0h%0h%0h exp 110", mem2reg, loadext, dsize); else passed++;
    total++; if (imm32 !== 32'hFFFF_FFFC) $display("FAIL lb_imm got %h exp fffffffc", imm32); else passed++;
    total++; if (rw !== 5'd2 || regwrite !== 1'b1 || alusrc !== 1'b1) $display("FAIL lb_rw got %0d %0h%0h exp 2 11", rw, regwrite, alusrc); else passed++;
    instr_in = 32'h3401_FFFF; // ORI r1,r0,0xFFFF
    tick;
    total++; if (imm32 !== 32'h0000_FFFF || aluctrl !== 4'd3) $display("FAIL ori got %h %0d exp 0000ffff 3", imm32, aluctrl); else passed++;
    instr_in = 32'hAC03_0000; // SW
    tick;
    total++; if (memwrite !== 1'b1 || regwrite !== 1'b0 || dsize !== 2'b10) $display("FAIL sw got %0h%0h %0d exp 10 2", memwrite, regwrite, dsize); else passed++;
    instr_in = 32'h9400_0000; // LHU
    tick;
    total++; if (loadext !== 1'b0 || dsize !== 2'b01) $display("FAIL lhu got %0h %0d exp 0 1", loadext, dsize); else passed++;
    instr_in = 32'h9804_0000; // LF f4
    tick;
    total++; if (fpoint !== 2'b01 || regwrite !== 1'b1 || dsize !== 2'b10) $display("FAIL lf got %0d %0h %0d exp 1 1 2", fpoint, regwrite, dsize); else passed++;
    wb_write(5'd4, 32'hDEAD_BEEF, 2'b01);
    instr_in = 32'hB804_0000; // SF f4,0(r0)
    tick;
    total++; if (fpoint !== 2'b10 || memwrite !== 1'b1 || busB !== 32'hDEAD_BEEF) $display("FAIL sf got %0d %0h %h exp 2 1 deadbeef", fpoint, memwrite, busB); else passed++;
    instr_in = 32'h6000_0000; tick; // SEQI
    total++; if (aluctrl !== 4'd8) $display("FAIL seqi got %0d exp 8", aluctrl); else passed++;
    instr_in = 32'h7400_0000; tick; // SGEI
    total++; if (aluctrl !== 4'd13) $display("FAIL sgei got %0d exp 13", aluctrl); else passed++;
    instr_in = 32'h5C00_0000; tick; // SRAI
    total++; if (aluctrl !== 4'd7) $display("FAIL srai got %0d exp 7", aluctrl); else passed++;
    instr_in = 32'h3C00_0000; tick; // LHI
    total++; if (aluctrl !== 4'd14) $display("FAIL lhi got %0d exp 14", aluctrl); else passed++;
    instr_in = 32'hFC00_0000; tick; // unknown opcode
    total++; if (regwrite !== 1'b0 || memwrite !== 1'b0 || mem2reg !== 1'b0) $display("FAIL nop got %0h%0h%0h exp 000", regwrite, memwrite, mem2reg); else passed++;
  endtask

  task automatic test_stall;
    instr_in = 32'h00A0_1820; stall = 1'b1;
    tick;
    total++; if (regwrite !== 1'b0 || memwrite !== 1'b0 || instr_out !== 32'd0) $display("FAIL stall_bubble got %0h%0h %h exp 00 00000000", regwrite, memwrite, instr_out); else passed++;
    instr_in = 32'h4CE0_0000;
    #1;
    total++; if (jump !== 1'b0 || jar !== 1'b0 || branchtarget !== 32'd0) $display("FAIL stall_redirect got %0h%0h %h exp 00 00000000", jump, jar, branchtarget); else passed++;
    stall = 1'b0;
    instr_in = 32'h0000_1820; // ADD r3,r0,r0 while writing r0
    wb_write(5'd0, 32'hFFFF_FFFF, 2'b00);
    total++; if (busA !== 32'd0) $display("FAIL r0_wt got %h exp 00000000", busA); else passed++;
    tick;
    total++; if (busA !== 32'd0) $display("FAIL r0_read got %h exp 00000000", busA); else passed++;
  endtask

  task automatic test_reset_mid;
    instr_in = 32'h00A0_1820;
    tick;
    total++; if (busA !== 32'hCAFE_BABE || regwrite !== 1'b1) $display("FAIL pre_rst got %h %0h exp cafebabe 1", busA, regwrite); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (busA !== 32'd0 || regwrite !== 1'b0 || instr_out !== 32'd0 || link !== 32'd0 || rw !== 5'd0) $display("FAIL async_rst got %h %0h %h %h %0d exp all 0", busA, regwrite, instr_out, link, rw); else passed++;
    tick;
    reset = 1'b1;
    tick;
    total++; if (busA !== 32'd0) $display("FAIL rst_r5 got %h exp 00000000", busA); else passed++;
    total++; if (rw !== 5'd3 || regwrite !== 1'b1 || instr_out !== 32'h00A0_1820) $display("FAIL rst_release got %0d %0h %h exp 3 1 00a01820", rw, regwrite, instr_out); else passed++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_branch;
    test_jump;
    test_imm;
    test_stall;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
